// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the issue hazard scoreboard.
package hazard_scoreboard_pkg;
   localparam int unsigned REG_W     = 5;
   localparam int unsigned NREG      = 32;
   localparam int unsigned LAT_W_DEF = 3;

   typedef logic [REG_W-1:0]     reg_addr_t;
   typedef logic [LAT_W_DEF-1:0] lat_t;
endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Per-operand bypass mux: youngest matching forwarding stage wins, r0 reads as zero.
module fwd_select
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NFWD = 3
) (
   input  logic [REG_W-1:0]      src_addr_i,
   input  logic [XLEN-1:0]       src_rf_i,
   input  logic [NFWD-1:0]       fwd_valid_i,
   input  logic [NFWD*REG_W-1:0] fwd_rd_i,
   input  logic [NFWD*XLEN-1:0]  fwd_val_i,
   output logic [XLEN-1:0]       val_o
);

   logic hit;

   always_comb begin
      hit   = 1'b0;
      val_o = src_rf_i;
      for (int unsigned j = 0; j < NFWD; j++) begin
         // A stage writing r0 can only match src r0, which is overridden below.
         if (!hit && fwd_valid_i[j] && (fwd_rd_i[j*REG_W +: REG_W] == src_addr_i)) begin
            val_o = fwd_val_i[j*XLEN +: XLEN];
            hit   = 1'b1;
         end
      end
      if (src_addr_i == '0) begin
         val_o = '0;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage scoreboard: per-register latency counters, RAW/WAW stall, operand bypass.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NSRC  = 2,
   parameter int unsigned NFWD  = 3,
   parameter int unsigned LAT_W = LAT_W_DEF
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  issue_valid,
   input  logic                  issue_we,
   input  logic [REG_W-1:0]      issue_rd,
   input  logic [LAT_W-1:0]      issue_lat,
   input  logic [NSRC-1:0]       src_used,
   input  logic [NSRC*REG_W-1:0] src_addr,
   input  logic [NSRC*XLEN-1:0]  src_rf,
   input  logic [NFWD-1:0]       fwd_valid,
   input  logic [NFWD*REG_W-1:0] fwd_rd,
   input  logic [NFWD*XLEN-1:0]  fwd_val,
   input  logic                  flush,
   output logic                  stall,
   output logic [NSRC*XLEN-1:0]  src_val,
   output logic [NREG-1:0]       busy_map,
   output logic [31:0]           stall_cycles
);

   logic [LAT_W-1:0] cnt_q [NREG];
   logic [LAT_W-1:0] cnt_d [NREG];
   logic [31:0]      stall_cnt_q, stall_cnt_d;
   logic             raw_hazard, waw_hazard, accept_wr;
   logic [NREG-1:0]  busy_raw;

   always_comb begin
      raw_hazard = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (src_used[i] && (src_addr[i*REG_W +: REG_W] != '0) &&
             (cnt_q[src_addr[i*REG_W +: REG_W]] != '0)) begin
            raw_hazard = 1'b1;
         end
      end
      waw_hazard = issue_valid && issue_we && (issue_rd != '0) && (cnt_q[issue_rd] > issue_lat);
      // Gated by resetn so pre-reset counter contents never reach the pipeline.
      stall      = resetn && !flush && (raw_hazard || waw_hazard);
      accept_wr  = issue_valid && !stall && !flush && issue_we && (issue_rd != '0);
   end

   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         cnt_d[r] = '0;
         if ((r != 0) && !flush) begin
            if (accept_wr && (issue_rd == reg_addr_t'(r))) begin
               cnt_d[r] = issue_lat;
            end else if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - 1'b1;
            end
         end
      end
      stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      busy_raw = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         busy_raw[r] = (cnt_q[r] != '0);
      end
      busy_map = resetn ? busy_raw : '0;
   end

   assign stall_cycles = stall_cnt_q;

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      fwd_select #(
         .XLEN (XLEN),
         .NFWD (NFWD)
      ) u_fwd_select (
         .src_addr_i  (src_addr[g*REG_W +: REG_W]),
         .src_rf_i    (src_rf[g*XLEN +: XLEN]),
         .fwd_valid_i (fwd_valid),
         .fwd_rd_i    (fwd_rd),
         .fwd_val_i   (fwd_val),
         .val_o       (src_val[g*XLEN +: XLEN])
      );
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: bypass vector table plus hazard/flush/reset sequences.
module tb_hazard_scoreboard;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NSRC  = 2;
   localparam int unsigned NFWD  = 3;
   localparam int unsigned LAT_W = 3;

   localparam int K_STALL = 0;
   localparam int K_SRC0  = 1;
   localparam int K_BUSY  = 2;
   localparam int K_SCYC  = 3;
   localparam int K_SRC1  = 4;

   logic                  clk = 1'b0;
   logic                  resetn;
   logic                  issue_valid, issue_we;
   logic [4:0]            issue_rd;
   logic [LAT_W-1:0]      issue_lat;
   logic [NSRC-1:0]       src_used;
   logic [NSRC*5-1:0]     src_addr;
   logic [NSRC*XLEN-1:0]  src_rf;
   logic [NFWD-1:0]       fwd_valid;
   logic [NFWD*5-1:0]     fwd_rd;
   logic [NFWD*XLEN-1:0]  fwd_val;
   logic                  flush;
   logic                  stall;
   logic [NSRC*XLEN-1:0]  src_val;
   logic [31:0]           busy_map;
   logic [31:0]           stall_cycles;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          kind;
      string       name;
      logic [31:0] value;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [4:0]  addr;
      logic [2:0]  fv;
      logic [4:0]  rd0, rd1, rd2;
      logic [31:0] v0, v1, v2;
      logic [31:0] rf;
      logic [31:0] expv;
   } fwd_vec_t;
   fwd_vec_t vecs [6];

   hazard_scoreboard #(
      .XLEN  (XLEN),
      .NSRC  (NSRC),
      .NFWD  (NFWD),
      .LAT_W (LAT_W)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .issue_valid  (issue_valid),
      .issue_we     (issue_we),
      .issue_rd     (issue_rd),
      .issue_lat    (issue_lat),
      .src_used     (src_used),
      .src_addr     (src_addr),
      .src_rf       (src_rf),
      .fwd_valid    (fwd_valid),
      .fwd_rd       (fwd_rd),
      .fwd_val      (fwd_val),
      .flush        (flush),
      .stall        (stall),
      .src_val      (src_val),
      .busy_map     (busy_map),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1);
   end

   function automatic logic [31:0] actual(input int kind);
      case (kind)
         K_STALL: return {31'b0, stall};
         K_SRC0:  return src_val[31:0];
         K_BUSY:  return busy_map;
         K_SCYC:  return stall_cycles;
         default: return src_val[63:32];
      endcase
   endfunction

   task automatic expect_val(input int kind, input string name, input logic [31:0] v);
      exp_q.push_back('{kind, name, v});
   endtask

   // Outputs are sampled 4 ns after inputs change, well clear of the next edge.
   task automatic drain();
      exp_t        e;
      logic [31:0] a;
      #4;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = actual(e.kind);
         checks++;
         if (a !== e.value) begin
            errors++;
            $display("FAIL %s: got %h want %h", e.name, a, e.value);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0; issue_lat = '0;
      src_used = '0; src_addr = '0; src_rf = '0;
      fwd_valid = '0; fwd_rd = '0; fwd_val = '0; flush = 1'b0;
   endtask

   task automatic offer_issue(input logic [4:0] rd, input logic [LAT_W-1:0] lat);
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd; issue_lat = lat;
   endtask

   task automatic use_src0(input logic [4:0] r);
      src_used = 2'b01; src_addr = {5'd0, r};
   endtask

   initial begin
      idle_inputs();
      resetn = 1'b0;
      tick();
      offer_issue(5'd6, 3'd4);
      flush = 1'b1;
      expect_val(K_STALL, "reset_stall", 32'd0);
      expect_val(K_BUSY,  "reset_busy",  32'd0);
      expect_val(K_SCYC,  "reset_scyc",  32'd0);
      drain();
      tick();
      idle_inputs();
      resetn = 1'b1;
      expect_val(K_BUSY, "post_reset_busy", 32'd0);
      expect_val(K_SCYC, "post_reset_scyc", 32'd0);
      drain();

      // Bypass priority and r0 vectors
      vecs[0] = '{5'd5,  3'b011, 5'd5,  5'd5,  5'd0,  32'h11,   32'h22, 32'h0,  32'h33, 32'h11};
      vecs[1] = '{5'd5,  3'b010, 5'd5,  5'd5,  5'd0,  32'h11,   32'h22, 32'h0,  32'h33, 32'h22};
      vecs[2] = '{5'd5,  3'b111, 5'd6,  5'd7,  5'd9,  32'h11,   32'h22, 32'h44, 32'h33, 32'h33};
      vecs[3] = '{5'd0,  3'b001, 5'd0,  5'd0,  5'd0,  32'hDEAD, 32'h0,  32'h0,  32'h55, 32'h0};
      vecs[4] = '{5'd12, 3'b100, 5'd12, 5'd12, 5'd12, 32'h61,   32'h66, 32'h77, 32'h88, 32'h77};
      vecs[5] = '{5'd12, 3'b110, 5'd12, 5'd12, 5'd12, 32'h61,   32'h66, 32'h77, 32'h88, 32'h66};
      for (int i = 0; i < 6; i++) begin
         src_addr  = {5'd0, vecs[i].addr};
         src_rf    = {32'hFFFF_0001, vecs[i].rf};
         fwd_valid = vecs[i].fv;
         fwd_rd    = {vecs[i].rd2, vecs[i].rd1, vecs[i].rd0};
         fwd_val   = {vecs[i].v2, vecs[i].v1, vecs[i].v0};
         expect_val(K_SRC0, $sformatf("fwd_vec%0d_src0", i), vecs[i].expv);
         expect_val(K_SRC1, $sformatf("fwd_vec%0d_src1_r0", i), 32'd0);
         drain();
      end
      idle_inputs();

      // Issue to r0 never becomes pending
      offer_issue(5'd0, 3'd7);
      tick();
      idle_inputs();
      expect_val(K_BUSY, "r0_issue_busy", 32'd0);
      drain();
      tick();

      // Load-use on r8 with latency 2
      offer_issue(5'd8, 3'd2);
      expect_val(K_STALL, "lu_issue_stall", 32'd0);
      drain();
      tick();
      idle_inputs();
      use_src0(5'd8);
      expect_val(K_STALL, "lu_c1_stall", 32'd1);
      expect_val(K_BUSY,  "lu_c1_busy",  32'h0000_0100);
      drain();
      tick();
      expect_val(K_STALL, "lu_c2_stall", 32'd1);
      drain();
      tick();
      fwd_valid = 3'b010;
      fwd_rd    = {5'd0, 5'd8, 5'd0};
      fwd_val   = {32'h0, 32'hCAFE_0008, 32'h0};
      src_rf    = {32'h0, 32'h1234_5678};
      expect_val(K_STALL, "lu_c3_stall", 32'd0);
      expect_val(K_SRC0,  "lu_c3_srcval", 32'hCAFE_0008);
      expect_val(K_SCYC,  "lu_scyc", 32'd2);
      drain();
      tick();
      idle_inputs();

      // WAW on r3: held while the older counter exceeds the new latency
      offer_issue(5'd3, 3'd5);
      tick();
      offer_issue(5'd3, 3'd1);
      for (int k = 0; k < 4; k++) begin
         expect_val(K_STALL, $sformatf("waw_wait%0d_stall", k), 32'd1);
         expect_val(K_BUSY,  $sformatf("waw_wait%0d_busy", k), 32'h0000_0008);
         drain();
         tick();
      end
      expect_val(K_STALL, "waw_accept_stall", 32'd0);
      drain();
      tick();
      idle_inputs();
      expect_val(K_BUSY, "waw_cnt1_busy", 32'h0000_0008);
      expect_val(K_SCYC, "waw_scyc", 32'd6);
      drain();
      tick();
      expect_val(K_BUSY, "waw_done_busy", 32'd0);
      drain();

      // Flush two cycles after a long-latency issue
      offer_issue(5'd9, 3'd7);
      tick();
      idle_inputs();
      use_src0(5'd9);
      expect_val(K_STALL, "fl_pre_stall", 32'd1);
      drain();
      tick();
      flush = 1'b1;
      offer_issue(5'd10, 3'd3);
      expect_val(K_STALL, "fl_flush_stall", 32'd0);
      drain();
      tick();
      flush = 1'b0;
      issue_valid = 1'b0;
      expect_val(K_BUSY,  "fl_after_busy",  32'd0);
      expect_val(K_STALL, "fl_after_stall", 32'd0);
      expect_val(K_SCYC,  "fl_scyc", 32'd7);
      drain();
      idle_inputs();
      tick();

      // Build cnt[4]=6 with stall_cycles=10, then reset mid-operation
      offer_issue(5'd20, 3'd3);
      tick();
      idle_inputs();
      use_src0(5'd20);
      for (int k = 0; k < 3; k++) tick();
      idle_inputs();
      offer_issue(5'd4, 3'd6);
      tick();
      idle_inputs();
      expect_val(K_BUSY, "mid_busy", 32'h0000_0010);
      expect_val(K_SCYC, "mid_scyc", 32'd10);
      drain();
      resetn = 1'b0;
      use_src0(5'd4);
      offer_issue(5'd5, 3'd3);
      expect_val(K_STALL, "mid_rst_stall", 32'd0);
      expect_val(K_BUSY,  "mid_rst_busy",  32'd0);
      drain();
      tick();
      resetn = 1'b1;
      issue_valid = 1'b0;
      expect_val(K_STALL, "mid_post_stall", 32'd0);
      expect_val(K_BUSY,  "mid_post_busy",  32'd0);
      expect_val(K_SCYC,  "mid_post_scyc",  32'd0);
      drain();
      idle_inputs();

      // Saturation: preload near the top, then keep stalling
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      offer_issue(5'd20, 3'd3);
      tick();
      idle_inputs();
      use_src0(5'd20);
      tick();
      expect_val(K_SCYC, "sat_reach", 32'hFFFF_FFFF);
      drain();
      tick();
      tick();
      expect_val(K_SCYC, "sat_hold", 32'hFFFF_FFFF);
      drain();
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
